// File: rtl/alu_muldiv_seq.sv
// Sequencer for unsigned MULTU/DIVU, one shared-ALU iteration per clock.
// Shift-add multiply and restoring divide, 64-bit result in hi/lo.
module alu_muldiv_seq #(
    parameter int         WIDTH   = 32,
    parameter logic [3:0] ALU_ADD = 4'b0010,
    parameter logic [3:0] ALU_SUB = 4'b0110
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    output logic             alu_own,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIN
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] mcand, mcand_nx;
    logic [WIDTH-1:0] divisor, divisor_nx;
    logic [WIDTH-1:0] hi_nx, lo_nx, sh;
    logic [CW-1:0]    count, count_nx;
    logic             dbz_nx, carry, take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hi          <= '0;
            lo          <= '0;
            count       <= '0;
            mcand       <= '0;
            divisor     <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nx;
            hi          <= hi_nx;
            lo          <= lo_nx;
            count       <= count_nx;
            mcand       <= mcand_nx;
            divisor     <= divisor_nx;
            div_by_zero <= dbz_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        hi_nx      = hi;
        lo_nx      = lo;
        count_nx   = count;
        mcand_nx   = mcand;
        divisor_nx = divisor;
        dbz_nx     = div_by_zero;
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = ALU_ADD;
        sh         = {hi[WIDTH-2:0], lo[WIDTH-1]};
        carry      = 1'b0;
        take       = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    count_nx = '0;
                    dbz_nx   = 1'b0;
                    if (!op) begin
                        mcand_nx = src_a;
                        hi_nx    = '0;
                        lo_nx    = src_b;
                        state_nx = MUL;
                    end else if (src_b != '0) begin
                        divisor_nx = src_b;
                        hi_nx      = '0;
                        lo_nx      = src_a;
                        state_nx   = DIV;
                    end else begin
                        // Divide by zero resolves immediately, ALU untouched
                        hi_nx    = src_a;
                        lo_nx    = '1;
                        dbz_nx   = 1'b1;
                        state_nx = FIN;
                    end
                end
            end
            MUL: begin
                alu_opcode = ALU_ADD;
                alu_a      = hi;
                alu_b      = lo[0] ? mcand : '0;
                // Lost carry of the 32-bit add shows up as a wrapped sum
                carry      = lo[0] & (alu_result < hi);
                hi_nx      = {carry, alu_result[WIDTH-1:1]};
                lo_nx      = {alu_result[0], lo[WIDTH-1:1]};
                count_nx   = count + 1'b1;
                if (count == LAST) state_nx = FIN;
            end
            DIV: begin
                alu_opcode = ALU_SUB;
                alu_a      = sh;
                alu_b      = divisor;
                // hi[31] set means the shifted remainder is 33 bits wide
                take       = hi[WIDTH-1] | (sh >= divisor);
                hi_nx      = take ? alu_result : sh;
                lo_nx      = {lo[WIDTH-2:0], take};
                count_nx   = count + 1'b1;
                if (count == LAST) state_nx = FIN;
            end
            FIN: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign alu_own = (state == MUL) || (state == DIV);
    assign busy    = (state != IDLE);
    assign done    = (state == FIN);

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that executes unsigned MULTU and DIVU by driving the shared 32-bit ALU one iteration per clock, using ALU add (4'b0010) and sub (4'b0110). It sits beside the ALU in the datapath. The main control unit issues a start pulse. The block then owns the ALU operand/opcode mux inputs until done. It returns 64-bit HI/LO results for the HI/LO register file.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH (only 32 is verified)
ALU_ADD, 4'b0010, ALU opcode driven for multiply iterations
ALU_SUB, 4'b0110, ALU opcode driven for divide iterations

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
op  input  1  0 = MULTU, 1 = DIVU; sampled with start
src_a  input  32  multiplicand / dividend
src_b  input  32  multiplier / divisor
alu_result  input  32  ALU Result port
alu_a  output  32  to ALU A (via datapath mux)
alu_b  output  32  to ALU B
alu_opcode  output  4  to ALU OpCode
alu_own  output  1  1 = datapath mux selects this block's ALU operands
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle completion pulse
div_by_zero  output  1  registered flag; valid with done; held until next start
hi  output  32  MULTU: product[63:32]; DIVU: remainder
lo  output  32  MULTU: product[31:0]; DIVU: quotient

Behaviour:
- FSM states: IDLE, MUL, DIV, FIN.
- Reset values: state = IDLE; hi, lo, count, done, busy, div_by_zero, alu_own, alu_a, alu_b = 0; alu_opcode = ALU_ADD.
- IDLE, start = 1, op = 0:
  - Latch mcand = src_a, hi = 0, lo = src_b, count = 0.
  - Go to MUL.
- IDLE, start = 1, op = 1, src_b != 0:
  - Latch divisor = src_b, hi = 0, lo = src_a, count = 0.
  - Go to DIV.
- IDLE, start = 1, op = 1, src_b == 0:
  - Set hi = src_a, lo = 32'hFFFFFFFF, div_by_zero = 1.
  - Go to FIN. No ALU cycles are used.
- MUL, each cycle:
  - Drive alu_opcode = ALU_ADD, alu_a = hi, alu_b = lo[0] ? mcand : 0.
  - Compute carry = lo[0] & (alu_result < hi), unsigned compare done locally.
  - Update hi <= {carry, alu_result[31:1]}, lo <= {alu_result[0], lo[31:1]}.
- DIV, each cycle (restoring):
  - Form sh = {hi[30:0], lo[31]} and m = hi[31].
  - Drive alu_opcode = ALU_SUB, alu_a = sh, alu_b = divisor.
  - If m | (sh >= divisor): hi <= alu_result, lo <= {lo[30:0], 1'b1}.
  - Otherwise: hi <= sh, lo <= {lo[30:0], 1'b0}.
  - Modulo-2^32 wrap of alu_result is required and correct.
- Iteration count:
  - count increments every MUL/DIV cycle.
  - After the cycle with count == WIDTH-1, go to FIN (exactly 32 iterations).
- FIN: done = 1 for exactly this cycle, then go to IDLE.
- alu_own = 1 only in MUL/DIV. busy = 1 in MUL/DIV/FIN.
- Latency:
  - Normal op: start at cycle T, done at T+33.
  - Divide by zero: done at T+1.
  - Back-to-back start is accepted in the cycle after done (IDLE).
- Result hold:
  - hi/lo are intermediate while busy.
  - Final at done; held stable until the next accepted start.
- start while not IDLE: ignored; no queuing, no effect on the current op.
- div_by_zero clears on the next accepted start.
- rst mid-operation: next cycle is IDLE with all outputs at reset values; no done pulse.
- rst and start in the same cycle: rst wins, start is dropped.
- The ALU is combinational: alu_result is consumed in the same cycle the operands are driven.

Test Plan:
- MULTU 7 x 6 -> done at T+33 (single pulse); hi = 0, lo = 42; alu_opcode = 4'b0010 throughout MUL.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001 (exercises carry); then MULTU 0x80000000 x 2 -> hi = 1, lo = 0.
- DIVU 100 / 7 -> lo = 14, hi = 2; DIVU 0xFFFFFFFF / 1 -> lo = 0xFFFFFFFF, hi = 0; DIVU 3 / 0x80000001 -> lo = 0, hi = 3; div_by_zero = 0 for all three.
- DIVU 5 / 0 -> done at T+1, div_by_zero = 1, hi = 5, lo = 0xFFFFFFFF, alu_own never asserted; next valid start clears div_by_zero.
- start pulsed at T+10 during MULTU 7 x 6 with other operands -> ignored, result still hi = 0, lo = 42 at T+33; new start at T+34 is accepted.
- rst asserted at T+15 of DIVU -> IDLE next cycle, all outputs 0, alu_opcode = 4'b0010, no done; a fresh DIVU 100 / 7 then completes correctly.
